imem_stream_loader: RTL and testbench

- Writer side of the instruction memory: boots the core by streaming a program image into the instruction memory write port.
- Accepts a byte stream over a valid/ready handshake and parses a framed image.
- Assembles 32-bit little-endian words, writes them at consecutive word addresses and holds the core in reset until a checksum-verified load completes.
- Sits between the host link (UART/JTAG byte bridge) and the instruction memory write port.

---
 rtl/imem_stream_loader.sv | 161 ++++++++++++++++
 tb/tb_imem_stream_loader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/imem_stream_loader.sv
// rtl/imem_stream_loader.sv - framed byte-stream loader for the instruction memory write port
// Optional inter-byte timeout guarded by LOADER_TIMEOUT_EN.
module imem_stream_loader #(
  parameter int          ADDR_W         = 10,
  parameter logic [7:0]  MAGIC          = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_t              state;
  logic [7:0]          len_lo;
  logic [ADDR_W:0]     len_words;
  logic [1:0]          byte_idx;
  logic [23:0]         word_buf;
  logic [ADDR_W-1:0]   addr;
  logic [7:0]          chk;
  logic                take;
  logic [16:0]         n_words;

  assign take    = in_valid && in_ready;
  assign n_words = {1'b0, in_data, len_lo};

`ifdef LOADER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;
  logic        frame_active;
  assign frame_active = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                        (state == S_DATA)   || (state == S_CHECK);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      in_ready     <= 1'b1;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
      core_hold    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      chk          <= '0;
      len_lo       <= '0;
      len_words    <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      addr         <= '0;
`ifdef LOADER_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (take && in_data == MAGIC) state <= S_LEN_LO;
        end
        S_LEN_LO: begin
          if (take) begin
            len_lo <= in_data;
            state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (take) begin
            if (n_words > MAX_WORDS) begin
              state     <= S_ERROR;
              error     <= 1'b1;
              core_hold <= 1'b1;
              in_ready  <= 1'b0;
            end else if (n_words == 17'd0) begin
              state <= S_CHECK;
            end else begin
              len_words <= n_words[ADDR_W:0];
              byte_idx  <= '0;
              addr      <= '0;
              state     <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (take) begin
            chk      <= chk ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              // Last lane goes straight to the write port; the buffer only holds lanes 0..2.
              imem_we      <= 1'b1;
              imem_waddr   <= addr;
              imem_wdata   <= {in_data, word_buf};
              addr         <= addr + 1'b1;
              words_loaded <= words_loaded + 1'b1;
              if ((words_loaded + 1'b1) == len_words) state <= S_CHECK;
            end else begin
              word_buf[8*byte_idx +: 8] <= in_data;
            end
          end
        end
        S_CHECK: begin
          if (take) begin
            in_ready <= 1'b0;
            if (in_data == chk) begin
              state     <= S_DONE;
              done      <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state     <= S_ERROR;
              error     <= 1'b1;
              core_hold <= 1'b1;
            end
          end
        end
        S_DONE, S_ERROR: begin
          if (restart) begin
            state        <= S_IDLE;
            in_ready     <= 1'b1;
            core_hold    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            addr         <= '0;
            chk          <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase

`ifdef LOADER_TIMEOUT_EN
      if (!frame_active || take) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TMO_LAST) begin
        tmo_cnt   <= '0;
        state     <= S_ERROR;
        error     <= 1'b1;
        core_hold <= 1'b1;
        in_ready  <= 1'b0;
      end else begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
// tb/tb_imem_stream_loader.sv - directed self-checking bench for imem_stream_loader
module tb_imem_stream_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              restart = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  int n_tests = 0;
  int n_fail  = 0;

  int          wr_cnt = 0;
  logic [31:0] wr_addr [8];
  logic [31:0] wr_data [8];

  imem_stream_loader #(.ADDR_W(ADDR_W), .MAGIC(8'hA5), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .restart(restart), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      if (wr_cnt < 8) begin
        wr_addr[wr_cnt] = 32'(imem_waddr);
        wr_data[wr_cnt] = imem_wdata;
      end
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $error("FAIL send_stall observed=in_ready0 expected=in_ready1 byte=%0h", b);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes [$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  32'(in_ready), 32'd1);
    check({tag, "_imem_we"},   32'(imem_we), 32'd0);
    check({tag, "_waddr"},     32'(imem_waddr), 32'd0);
    check({tag, "_wdata"},     imem_wdata, 32'd0);
    check({tag, "_core_hold"}, 32'(core_hold), 32'd1);
    check({tag, "_done"},      32'(done), 32'd0);
    check({tag, "_error"},     32'(error), 32'd0);
    check({tag, "_words"},     32'(words_loaded), 32'd0);
  endtask

  initial begin
    // Reset
    idle(2);
    rst = 1'b0;
    check_reset_values("reset");

    // Two-word frame with good checksum
    wr_cnt = 0;
    send_frame('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'hB7, 8'h02, 8'h01, 8'h00, 8'hA7});
    check("f1_wr_cnt", 32'(wr_cnt), 32'd2);
    check("f1_addr0", wr_addr[0], 32'd0);
    check("f1_data0", wr_data[0], 32'h00000013);
    check("f1_addr1", wr_addr[1], 32'd1);
    check("f1_data1", wr_data[1], 32'h000102B7);
    check("f1_done", 32'(done), 32'd1);
    check("f1_hold", 32'(core_hold), 32'd0);
    check("f1_words", 32'(words_loaded), 32'd2);
    check("f1_ready", 32'(in_ready), 32'd0);

    // Byte offered while not ready is ignored
    in_valid = 1'b1; in_data = 8'hA5;
    idle(2);
    in_valid = 1'b0;
    check("nr_done", 32'(done), 32'd1);
    check("nr_words", 32'(words_loaded), 32'd2);

    pulse_restart();
    check("rs1_done", 32'(done), 32'd0);
    check("rs1_hold", 32'(core_hold), 32'd1);
    check("rs1_ready", 32'(in_ready), 32'd1);
    check("rs1_words", 32'(words_loaded), 32'd0);

    // Garbage then empty frame
    wr_cnt = 0;
    send_frame('{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00});
    check("f2_done", 32'(done), 32'd1);
    check("f2_err", 32'(error), 32'd0);
    check("f2_wr_cnt", 32'(wr_cnt), 32'd0);
    pulse_restart();

    // One word, bad checksum
    wr_cnt = 0;
    send_frame('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00});
    check("f3_wr_cnt", 32'(wr_cnt), 32'd1);
    check("f3_addr0", wr_addr[0], 32'd0);
    check("f3_data0", wr_data[0], 32'h44332211);
    check("f3_err", 32'(error), 32'd1);
    check("f3_hold", 32'(core_hold), 32'd1);
    check("f3_done", 32'(done), 32'd0);
    check("f3_words", 32'(words_loaded), 32'd1);
    pulse_restart();
    check("rs3_err", 32'(error), 32'd0);
    check("rs3_words", 32'(words_loaded), 32'd0);
    check("rs3_ready", 32'(in_ready), 32'd1);

    // Oversize length 1025
    wr_cnt = 0;
    send_frame('{8'hA5, 8'h01, 8'h04});
    check("f4_err", 32'(error), 32'd1);
    check("f4_ready", 32'(in_ready), 32'd0);
    idle(2);
    check("f4_wr_cnt", 32'(wr_cnt), 32'd0);
    pulse_restart();

    // Reset during a half-assembled word
    wr_cnt = 0;
    send_frame('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00});
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3);
    check("f5_wr_cnt", 32'(wr_cnt), 32'd0);
    check_reset_values("f5");
    send_frame('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'hB7, 8'h02, 8'h01, 8'h00, 8'hA7});
    check("f5b_wr_cnt", 32'(wr_cnt), 32'd2);
    check("f5b_data0", wr_data[0], 32'h00000013);
    check("f5b_data1", wr_data[1], 32'h000102B7);
    check("f5b_done", 32'(done), 32'd1);
    pulse_restart();

    // Stall after MAGIC
    send_byte(8'hA5);
    idle(20);
`ifdef LOADER_TIMEOUT_EN
    check("tmo_err", 32'(error), 32'd1);
    check("tmo_hold", 32'(core_hold), 32'd1);
`else
    check("tmo_err", 32'(error), 32'd0);
    check("tmo_ready", 32'(in_ready), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
